// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter: arbiter state encoding,
// memory owner encoding (also used by bench probes) and a helper that sizes
// saturating counters from their maximum value.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic {
      ARB_CPU  = 1'b0,
      ARB_HOST = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int cnt_bits(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_arb_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at MAX. Clear has priority over enable.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high; zeroes the count
//   enable in   count up by one this cycle (ignored at MAX)
//   clear  in   zero the count this cycle
//   count  out  current value
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int           W   = 4,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         clear,
   output logic [W-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/memory_port_arbiter.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter
// Shares one single-ported memory between the multicycle CPU and a host/loader
// port. The CPU normally wins; a waiting host gets one forced slot after
// HOST_WAIT_MAX denied cycles, and a locked host burst yields one slot to a
// requesting CPU after HOST_BURST consecutive grants.
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU access request (held while stalled)
//   cpu_rdata                        memory read data, valid cycle after grant
//   cpu_stall                        CPU must hold its access (combinational)
//   host_req/we/lock/addr/wdata      host access request, held until host_ack
//   host_rdata                       host read data, valid while host_ack=1
//   host_ack                         one-cycle pulse the cycle after a host grant
//   mem_addr/wdata/we, mem_rdata     memory interface (sync read, 1-cycle)
//   stall_count                      saturating count of stalled CPU cycles
// ---------------------------------------------------------------------------
module memory_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W        = 16,
   parameter int ADDR_W        = 16,
   parameter int HOST_BURST    = 4,
   parameter int HOST_WAIT_MAX = 8,
   parameter int CNT_W         = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic              host_lock,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  stall_count
);

   localparam int WAIT_W  = cnt_bits(HOST_WAIT_MAX);
   localparam int BURST_W = cnt_bits(HOST_BURST);
   localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(HOST_WAIT_MAX);
   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(HOST_BURST);

   arb_state_t          state;
   arb_state_t          state_next;
   owner_t              owner;
   logic                grant_host;
   logic                grant_cpu;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [BURST_W-1:0]  burst_cnt;
   logic                burst_step;
   logic [DATA_W-1:0]   rdata_hold;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ARB_CPU;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ARB_CPU:  if (grant_host && host_lock) state_next = ARB_HOST;
         ARB_HOST: if (!grant_host)             state_next = ARB_CPU;
         default:                               state_next = ARB_CPU;
      endcase
   end

   // Grant decision and memory mux. Reset suppresses every grant so nothing
   // can write memory while the system is being reset.
   always_comb begin
      grant_host = 1'b0;
      grant_cpu  = 1'b0;
      if (!reset) begin
         case (state)
            ARB_CPU: begin
               if (host_req && (!cpu_req || (wait_cnt == WAIT_LIMIT))) begin
                  grant_host = 1'b1;
               end else if (cpu_req) begin
                  grant_cpu = 1'b1;
               end
            end
            ARB_HOST: begin
               if (host_req && host_lock && ((burst_cnt < BURST_LIMIT) || !cpu_req)) begin
                  grant_host = 1'b1;
               end else if (cpu_req) begin
                  grant_cpu = 1'b1;
               end
            end
            default: begin
               grant_host = 1'b0;
               grant_cpu  = 1'b0;
            end
         endcase
      end

      owner = grant_host ? OWN_HOST : (grant_cpu ? OWN_CPU : OWN_NONE);

      // Idle memory keeps the CPU address so the array sees a stable fetch address.
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = 1'b0;
      case (owner)
         OWN_HOST: begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
         end
         OWN_CPU:  mem_we = cpu_we;
         default:  mem_we = 1'b0;
      endcase

      cpu_stall = cpu_req && !grant_cpu && !reset;
   end

   // A burst step is any locked host grant; anything else ends the burst.
   assign burst_step = grant_host && host_lock;

   sat_counter #(.W(WAIT_W), .MAX(WAIT_LIMIT)) u_wait_cnt (
      .clock  (clock),
      .reset  (reset),
      .enable (host_req && !grant_host),
      .clear  (grant_host),
      .count  (wait_cnt)
   );

   sat_counter #(.W(BURST_W), .MAX(BURST_LIMIT)) u_burst_cnt (
      .clock  (clock),
      .reset  (reset),
      .enable (burst_step),
      .clear  (!burst_step),
      .count  (burst_cnt)
   );

   sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_stall_cnt (
      .clock  (clock),
      .reset  (reset),
      .enable (cpu_stall),
      .clear  (1'b0),
      .count  (stall_count)
   );

   // Host response: ack follows the grant by one cycle, matching the memory's
   // read latency. The read word is passed straight through during the ack
   // cycle and held afterwards.
   always_ff @(posedge clock) begin
      if (reset) begin
         host_ack   <= 1'b0;
         rdata_hold <= '0;
      end else begin
         host_ack <= grant_host;
         if (host_ack) begin
            rdata_hold <= mem_rdata;
         end
      end
   end

   assign host_rdata = host_ack ? mem_rdata : rdata_hold;
   assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;
   import mem_arb_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        host_req, host_we, host_lock;
   logic [15:0] host_addr, host_wdata, host_rdata;
   logic        host_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
   logic [15:0] stall_count;

   logic [15:0] mem [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   memory_port_arbiter #(
      .DATA_W(16), .ADDR_W(16), .HOST_BURST(4), .HOST_WAIT_MAX(8), .CNT_W(16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_lock   (host_lock),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_rdata  (host_rdata),
      .host_ack    (host_ack),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_rdata   (mem_rdata),
      .stall_count (stall_count)
   );

   // Synchronous-read memory, read-before-write.
   always @(posedge clock) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
      host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0;
      host_addr = 16'h0; host_wdata = 16'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [39:0] gv;
      int n;
      int c;
      logic [15:0] stall_mid;

      for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 + i);

      // Reset: both ports requesting, nothing may reach memory or stall the CPU.
      idle_inputs();
      reset = 1'b1;
      cpu_req = 1'b1; cpu_addr = 16'h0007;
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0008; host_wdata = 16'hDEAD;
      @(negedge clock);
      check_val("rst_stall", 32'(cpu_stall), 0);
      check_val("rst_mem_we", 32'(mem_we), 0);
      step();
      idle_inputs();
      step();
      reset = 1'b0;
      @(negedge clock);
      check_val("rst_ack", 32'(host_ack), 0);
      check_val("rst_hrdata", 32'(host_rdata), 0);
      check_val("rst_stall_cnt", 32'(stall_count), 0);
      check_val("rst_state", 32'(dut.state), 32'(ARB_CPU));

      // 1: CPU only
      step();
      for (int i = 0; i < 5; i++) begin
         cpu_req = (i < 4); cpu_addr = 16'(i);
         @(negedge clock);
         if (i < 4) begin
            check_val($sformatf("t1_stall%0d", i), 32'(cpu_stall), 0);
            check_val($sformatf("t1_addr%0d", i), 32'(mem_addr), 32'(i));
         end
         if (i > 0) check_val($sformatf("t1_rdata%0d", i), 32'(cpu_rdata), 32'(16'h1000 + i - 1));
         step();
      end
      check_val("t1_stall_cnt", 32'(stall_count), 0);

      // 2: host preload with CPU idle, then CPU fetch
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0000; host_wdata = 16'h13b0;
      @(negedge clock);
      check_val("t2_grant_we", 32'(mem_we), 1);
      check_val("t2_grant_addr", 32'(mem_addr), 32'h0000);
      step();
      host_req = 1'b0; host_we = 1'b0;
      @(negedge clock);
      check_val("t2_ack", 32'(host_ack), 1);
      step();
      cpu_req = 1'b1; cpu_addr = 16'h0000;
      @(negedge clock);
      check_val("t2_ack_gone", 32'(host_ack), 0);
      check_val("t2_fetch_stall", 32'(cpu_stall), 0);
      step();
      cpu_req = 1'b0;
      @(negedge clock);
      check_val("t2_fetch_data", 32'(cpu_rdata), 32'h13b0);
      step();

      // 3: contention from cycle 0; host forced in at cycle 8
      cpu_req = 1'b1; cpu_addr = 16'h0020;
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0030; host_wdata = 16'h5555;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clock);
         check_val($sformatf("t3_stall_c%0d", k), 32'(cpu_stall), 32'(k == 8));
         check_val($sformatf("t3_we_c%0d", k), 32'(mem_we), 32'(k == 8));
         step();
      end
      host_req = 1'b0; host_we = 1'b0;
      @(negedge clock);
      check_val("t3_ack", 32'(host_ack), 1);
      check_val("t3_stall_cnt", 32'(stall_count), 1);
      check_val("t3_mem", 32'(mem[8'h30]), 32'h5555);
      step();
      cpu_req = 1'b0;

      // 4: locked burst of 6 writes against a continuously requesting CPU
      do_reset();
      cpu_req = 1'b1; cpu_addr = 16'h0020;
      host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1;
      n = 0; c = 0; gv = '0; stall_mid = 16'hFFFF;
      while (n < 6 && c < 40) begin
         host_addr = 16'(16'h0040 + n); host_wdata = 16'(16'hA000 + n);
         @(negedge clock);
         gv[c] = mem_we;
         if (c == 13) stall_mid = stall_count;
         if (mem_we) n++;
         c++;
         step();
      end
      host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0;
      @(negedge clock);
      check_val("t4_writes", 32'(n), 6);
      check_val("t4_pattern", gv[31:0], 32'h0030_0F00);
      check_val("t4_stall_after_burst", 32'(stall_mid), 4);
      check_val("t4_stall_cnt", 32'(stall_count), 6);
      check_val("t4_ack", 32'(host_ack), 1);
      check_val("t4_mem_last", 32'(mem[8'h45]), 32'hA005);
      step();
      cpu_req = 1'b0;

      // 5: reset in the second burst cycle
      do_reset();
      host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1;
      host_addr = 16'h0050; host_wdata = 16'h1111;
      @(negedge clock);
      check_val("t5_first_grant", 32'(mem_we), 1);
      step();
      reset = 1'b1; cpu_req = 1'b1;
      host_addr = 16'h0051; host_wdata = 16'h2222;
      @(negedge clock);
      check_val("t5_rst_we", 32'(mem_we), 0);
      check_val("t5_rst_stall", 32'(cpu_stall), 0);
      step();
      reset = 1'b0; idle_inputs();
      @(negedge clock);
      check_val("t5_no_ack", 32'(host_ack), 0);
      check_val("t5_state", 32'(dut.state), 32'(ARB_CPU));
      check_val("t5_we_after", 32'(mem_we), 0);
      check_val("t5_stall_cnt", 32'(stall_count), 0);
      check_val("t5_mem_untouched", 32'(mem[8'h51]), 32'h1051);
      step();

      // 6: host write then CPU load, then host read-back
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 16'hBEEF;
      step();
      host_req = 1'b0; host_we = 1'b0;
      step();
      cpu_req = 1'b1; cpu_addr = 16'h0010;
      step();
      cpu_req = 1'b0;
      @(negedge clock);
      check_val("t6_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
      step();
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
      step();
      host_req = 1'b0;
      @(negedge clock);
      check_val("t6_host_ack", 32'(host_ack), 1);
      check_val("t6_host_rdata", 32'(host_rdata), 32'hBEEF);
      step();
      @(negedge clock);
      check_val("t6_ack_pulse", 32'(host_ack), 0);
      check_val("t6_rdata_hold", 32'(host_rdata), 32'hBEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
